spi_master_ctrl: RTL

//  SPI master transaction engine, mode 0 (CPOL=0, CPHA=0), MSB first.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_clk_div.sv | 40 ++++
 rtl/spi_master_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master transaction engine.
// Holds the FSM state encoding, chip-select index width and counter sizing.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } spi_state_t;

    localparam int CS_IDX_W       = 4;
    localparam int DEFAULT_DATA_W = 8;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SPI clock generator: divides clk by 2*CLK_DIV while enabled, idles low otherwise.
// Strobes flag the cycle whose closing edge makes sclk rise or fall.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int               DIV_W    = clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             terminal;

    assign terminal = en && (div_cnt == DIV_LAST);
    assign rise_stb = terminal && !sclk;
    assign fall_stb = terminal && sclk;

    // Dropping the enable parks the divider at zero with sclk low, so every
    // SHIFT phase starts with a full half-period before the first rise.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master, MSB first: one request at a time, framed by cs_en with
// configurable setup/hold, driving a downstream 4-to-16 chip-select decoder.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CS_IDX_W-1:0] slave_idx,
    input  logic [DATA_W-1:0]   tx_data,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   rx_data,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso,
    output logic [CS_IDX_W-1:0] cs_idx,
    output logic                cs_en
);

    localparam int BIT_W = clog2(DATA_W);
    localparam int PH_W  = clog2(((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD) + 1);

    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);
    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(CS_HOLD - 1);

    spi_state_t        state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [PH_W-1:0]   phase_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic              rise_stb;
    logic              fall_stb;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk      (clk),
        .rst      (rst),
        .en       (state == SHIFT),
        .sclk     (sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // tx_shift holds the bits still to be sent, left-aligned; the MSB goes
    // straight onto mosi at accept so it is valid through the whole setup window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mosi      <= 1'b0;
            cs_en     <= 1'b0;
            cs_idx    <= '0;
            rx_data   <= '0;
            bit_cnt   <= '0;
            phase_cnt <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SETUP;
                        busy      <= 1'b1;
                        cs_en     <= 1'b1;
                        cs_idx    <= slave_idx;
                        mosi      <= tx_data[DATA_W-1];
                        tx_shift  <= {tx_data[DATA_W-2:0], 1'b0};
                        bit_cnt   <= '0;
                        phase_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (phase_cnt == SETUP_LAST) begin
                        state     <= SHIFT;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (rise_stb) begin
                        rx_shift <= {rx_shift[DATA_W-2:0], miso};
                    end
                    // The last falling edge closes the frame and leaves mosi on the final bit.
                    if (fall_stb) begin
                        if (bit_cnt == BIT_LAST) begin
                            state <= HOLD;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            mosi     <= tx_shift[DATA_W-1];
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (phase_cnt == HOLD_LAST) begin
                        state     <= IDLE;
                        phase_cnt <= '0;
                        busy      <= 1'b0;
                        cs_en     <= 1'b0;
                        done      <= 1'b1;
                        rx_data   <= rx_shift;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
